bcd_timer_display: RTL and testbench

Parametrised stopwatch/countdown-timer core with built-in button conditioning and multiplexed common-anode 7-segment drive, replacing the fixed 4-digit, derived-clock stopwatch. Everything runs on the single board clock using clock-enable pulses; digit count, tick rate, scan rate and debounce time are parameters. It sits between the board push-buttons and switches and the N-digit display. Unlike the previous block, up or down mode is selected explicitly, and countdown stops at zero and raises `done`.

---
 rtl/bcd_timer_display.sv | 242 ++++++++++++++++++++++++
 tb/tb_bcd_timer_display.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_display.sv
// N-digit BCD stopwatch/countdown timer with debounced buttons and a multiplexed common-anode 7-segment drive.
// Outputs are registered: value moves 1 cycle after a tick, and seg/an follow idx/value by 1 cycle.

module bcd_btn_cond #(
  parameter int DEB_CYCLES = 3_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          deb_prev_q, deb_prev_d;
  logic          pulse_q, pulse_d;
  logic          deb;

  // Debounced level needs the counter saturated and the input still high,
  // so a burst of exactly DEB_CYCLES high samples is still rejected.
  always_comb begin
    sync_d = {sync_q[0], btn};
    cnt_d  = cnt_q;
    if (!sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != DW'(DEB_CYCLES)) begin
      cnt_d = cnt_q + DW'(1);
    end
    deb        = sync_q[1] && (cnt_q == DW'(DEB_CYCLES));
    deb_prev_d = deb;
    pulse_d    = deb && !deb_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      deb_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      deb_prev_q <= deb_prev_d;
      pulse_q    <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

module bcd_timer_display #(
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 1_000_000,
  parameter int SCAN_DIV   = 100_000,
  parameter int DEB_CYCLES = 3_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  mode,
  input  logic                  btn_load,
  input  logic                  btn_run,
  output logic [4*DIGITS-1:0]   value,
  output logic                  running,
  output logic                  done,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [VW-1:0] value_q, value_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic [TW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          load_p, run_p, tick;
  logic [VW-1:0] dec_val;

  bcd_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_load (
    .clk(clk), .rst(rst), .btn(btn_load), .pulse(load_p)
  );
  bcd_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_run (
    .clk(clk), .rst(rst), .btn(btn_run), .pulse(run_p)
  );

  function automatic logic [VW-1:0] bcd_clamp(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    value_d = value_q;
    dec_val = bcd_dec(value_q);
    tick    = (state_q == S_RUN) && (pre_q == TW'(TICK_DIV - 1));
    // Prescaler only advances in RUN; any other state parks it at 0 so a start begins a full period.
    if (state_q == S_RUN) pre_d = tick ? '0 : pre_q + TW'(1);
    else                  pre_d = '0;

    case (state_q)
      S_IDLE: begin
        if (load_p) begin
          value_d = bcd_clamp(load_val);
        end else if (run_p) begin
          dir_d   = mode;
          state_d = (mode && value_q == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (run_p) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (!dir_q) begin
            value_d = bcd_inc(value_q);
          end else begin
            value_d = dec_val;
            if (dec_val == '0) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (load_p) begin
          value_d = bcd_clamp(load_val);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);

    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = seg_decode(value_q[4*idx_q +: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      value_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pre_q     <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      an_q      <= ~DIGITS'(1);
      seg_q     <= 7'b1000000;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      value_q   <= value_d;
      running_q <= running_d;
      done_q    <= done_d;
      pre_q     <= pre_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign value   = value_q;
  assign running = running_q;
  assign done    = done_q;
  assign seg     = seg_q;
  assign an      = an_q;
endmodule

// File: tb/tb_bcd_timer_display.sv
// Directed bench for bcd_timer_display with small divider settings; expected values hand-derived.

module tb_bcd_timer_display;
  logic        clk;
  logic        rst;
  logic [15:0] load_val;
  logic        mode;
  logic        btn_load;
  logic        btn_run;
  logic [15:0] value;
  logic        running;
  logic        done;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_timer_display #(
    .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .DEB_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .load_val(load_val), .mode(mode),
    .btn_load(btn_load), .btn_run(btn_run), .value(value),
    .running(running), .done(done), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raises the buttons at a falling edge and returns 7 falling edges later,
  // the first sample at which the FSM has acted on the resulting pulse.
  task automatic press(input logic r, input logic l);
    btn_run  = r;
    btn_load = l;
    repeat (7) @(negedge clk);
    btn_run  = 1'b0;
    btn_load = 1'b0;
  endtask

  task automatic wait_change(output logic [15:0] v, output int n);
    logic [15:0] old;
    old = value;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (value == old && n < 40);
    v = value;
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] vp;
    logic [3:0]  exp_an;
    int n;
    int seen;
    int first;
    int changes;

    rst = 1'b1; load_val = '0; mode = 1'b0; btn_load = 1'b0; btn_run = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset values and scan sequence
    check("rst_value", value, 16'h0000);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == 0) exp_an = 4'b1110;
      else        exp_an = ~(4'b0001 << (((k - 1) / 2) % 4));
      check("scan_an", an, exp_an);
      check("scan_seg", seg, 7'b1000000);
      @(negedge clk);
    end
    check("scan_value", value, 16'h0000);

    // Stopwatch wrap
    load_val = 16'h9998;
    press(1'b0, 1'b1);
    check("sw_load", value, 16'h9998);
    check("sw_load_idle", running, 0);
    mode = 1'b0;
    press(1'b1, 1'b0);
    check("sw_running", running, 1);
    wait_change(v, n);
    check("sw_tick1_lat", n, 4);
    check("sw_tick1", v, 16'h9999);
    wait_change(v, n);
    check("sw_tick2_lat", n, 4);
    check("sw_wrap", v, 16'h0000);
    check("sw_wrap_running", running, 1);
    check("sw_wrap_done", done, 0);

    // Load ignored in RUN, pause holds, load clamps
    load_val = 16'h5555;
    press(1'b0, 1'b1);
    check("run_load_ignored", value == 16'h5555, 0);
    check("run_load_running", running, 1);
    repeat (2) @(negedge clk);
    press(1'b1, 1'b0);
    check("pause_running", running, 0);
    vp = value;
    repeat (10) @(negedge clk);
    check("pause_hold", value, vp);
    load_val = 16'h12A4;
    press(1'b0, 1'b1);
    check("clamp_load", value, 16'h1294);
    check("clamp_idle", running, 0);
    check("clamp_done", done, 0);

    // Debounce: 3-cycle glitch rejected, long hold gives one pulse at 6 cycles
    repeat (4) @(negedge clk);
    mode = 1'b0;
    seen = 0;
    btn_run = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 3) btn_run = 1'b0;
      if (dut.run_p) seen++;
    end
    check("glitch_no_pulse", seen, 0);
    check("glitch_idle", running, 0);
    seen = 0;
    first = 0;
    btn_run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dut.run_p) begin
        seen++;
        first = i;
      end
    end
    btn_run = 1'b0;
    check("hold_one_pulse", seen, 1);
    check("hold_pulse_lat", first, 6);
    check("hold_started", running, 1);

    // Priority: simultaneous load and run in IDLE loads only; reset mid-RUN
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0);
    check("prio_paused", running, 0);
    repeat (3) @(negedge clk);
    load_val = 16'h0042;
    press(1'b1, 1'b1);
    check("prio_loaded", value, 16'h0042);
    check("prio_no_start", running, 0);
    repeat (8) @(negedge clk);
    check("prio_still_idle", running, 0);
    press(1'b1, 1'b0);
    check("prio_run", running, 1);
    repeat (6) @(negedge clk);
    check("prio_count", value, 16'h0043);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_value", value, 16'h0000);
    check("midrst_running", running, 0);
    check("midrst_done", done, 0);
    check("midrst_an", an, 4'b1110);
    check("midrst_seg", seg, 7'b1000000);

    // Timer expiry
    repeat (3) @(negedge clk);
    load_val = 16'h0102;
    press(1'b0, 1'b1);
    check("tm_load", value, 16'h0102);
    mode = 1'b1;
    press(1'b1, 1'b0);
    check("tm_running", running, 1);
    check("tm_not_done", done, 0);
    wait_change(v, n);
    check("tm_tick1_lat", n, 4);
    check("tm_tick1", v, 16'h0101);
    mode = 1'b0;
    wait_change(v, n);
    check("tm_tick2", v, 16'h0100);
    wait_change(v, n);
    check("tm_borrow", v, 16'h0099);
    changes = 3;
    while (value != 16'h0000 && changes < 200) begin
      wait_change(v, n);
      changes++;
    end
    check("tm_ticks", changes, 102);
    check("tm_last_lat", n, 4);
    check("tm_zero", value, 16'h0000);
    check("tm_done", done, 1);
    check("tm_stopped", running, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("tm_hold", {done, value}, {1'b1, 16'h0000});
    end
    press(1'b1, 1'b0);
    check("done_run_ignored", done, 1);
    check("done_run_not_running", running, 0);
    repeat (3) @(negedge clk);
    load_val = 16'h0000;
    press(1'b0, 1'b1);
    check("done_load_clears", done, 0);
    check("done_load_idle", running, 0);
    repeat (3) @(negedge clk);
    mode = 1'b1;
    press(1'b1, 1'b0);
    check("zero_start_done", done, 1);
    check("zero_start_running", running, 0);
    check("zero_start_value", value, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
